// File: rtl/seg_scan_driver_if.sv
// Bundle of the display-driver data signals.
//   digits      : four hex nibbles, digit 0 rightmost
//   dp_in       : per-digit decimal point request, active-high
//   blink_mask  : per-digit blink enable
//   an          : anode enables, active-low
//   seg         : cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n        : decimal point cathode, active-low
//   frame_start : one-cycle pulse when a new digit snapshot is taken
// The master drives the digit data and observes the display pins; the slave is the driver.
interface seg_scan_driver_if;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    modport master (
        output digits, dp_in, blink_mask,
        input  an, seg, dp_n, frame_start
    );

    modport slave (
        input  digits, dp_in, blink_mask,
        output an, seg, dp_n, frame_start
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
// Scans the digits in slots of SCAN_DIV cycles. Each slot starts with BLANK_CYC cycles
// in which all anodes are off, which prevents ghosting. Digit data is latched once per
// frame, on the slot 3 -> slot 0 transition, so a multi-digit value always appears
// coherently on the display. A free-running blink timer can darken selected digits.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seg_scan_driver_if (digit data in, display pins out)
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 250000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CntW-1:0]   CntLast   = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]   BlankEnd  = CntW'(BLANK_CYC);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    logic [CntW-1:0]   cnt_q;
    logic [1:0]        idx_q;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_phase_q;
    logic [15:0]       snap_digits_q;
    logic [3:0]        snap_dp_q;

    logic [3:0] an_q,  an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_n_q, dp_n_d;
    logic       frame_start_q;

    logic       slot_end;
    logic       frame_load;
    logic [3:0] cur_nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end   = (cnt_q == CntLast);
    assign frame_load = slot_end && (idx_q == 2'd3);
    assign cur_nib    = snap_digits_q[{idx_q, 2'b00} +: 4];

    // Display shows only snapshot data; blink_mask is deliberately read live.
    always_comb begin
        an_d   = 4'b1111;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        if ((cnt_q >= BlankEnd) && !(blink_phase_q && bus.blink_mask[idx_q])) begin
            an_d   = ~(4'b0001 << idx_q);
            seg_d  = hex_to_seg(cur_nib);
            dp_n_d = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_digits_q <= 16'h0000;
            snap_dp_q     <= 4'h0;
            an_q          <= 4'b1111;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end

            if (frame_load) begin
                snap_digits_q <= bus.digits;
                snap_dp_q     <= bus.dp_in;
            end
            frame_start_q <= frame_load;

            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = frame_start_q;

endmodule
